mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning data-memory byte count; legal values are 2..256, power of two.
REQ-002 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: stall  in  1  hold the EX/MEM register; flush  in  1  replace the next EX/MEM entry with a bubble.
REQ-004 SHALL have ports: ex_reg_write  in  1  writeback enable; ex_mem_read  in  1  load; ex_mem_write  in  1  store; ex_rd  in  2  destination register.
REQ-005 SHALL have ports: ex_alu_result  in  8  ALU result, which is also the load/store address; ex_store_data  in  8  store data.
REQ-006 SHALL have ports: mem_reg_write  out  1; mem_rd  out  2; mem_result  out  8 (all three feed the MEM/WB register).
REQ-007 SHALL have ports: mem_is_load  out  1  load in MEM stage, for the hazard unit; fwd_valid  out  1; fwd_rd  out  2; fwd_data  out  8  forwarding to EX.
REQ-008 SHALL have ports io_in  in  8 and io_out  out  8, used only when MEM_IO_EN is defined; io_out is tied to 0 otherwise.

Function
REQ-009 SHALL register all ex_* inputs into an internal EX/MEM register on each rising clk edge, unless stalled or flushed.
REQ-010 SHALL load a bubble when flush=1 (reg_write, mem_read, mem_write, rd, alu_result and store_data all 0); flush takes priority over stall.
REQ-011 SHALL hold the EX/MEM register unchanged when stall=1 and flush=0.
REQ-012 SHALL address memory with the registered alu_result[log2(DEPTH)-1:0]; upper address bits are ignored, so addresses wrap.
REQ-013 SHALL read combinationally: mem_result = mem[addr] when registered mem_read=1, else the registered alu_result.
REQ-014 SHALL write mem[addr] <= store_data on the rising edge that ends the MEM cycle, only when registered mem_write=1, stall=0 and flush=0.
REQ-015 SHALL therefore perform each store exactly once, however many cycles the stage is stalled.
REQ-016 SHALL give a load that follows a store to the same address in the next MEM cycle the newly stored value.
REQ-017 SHALL give a simultaneous mem_read=1 and mem_write=1 in one entry read-old-data in that cycle, with the write committed at its end.
REQ-018 SHALL drive mem_reg_write = registered reg_write and mem_rd = registered rd; mem_is_load = registered mem_read.
REQ-019 SHALL drive fwd_valid = registered reg_write, fwd_rd = mem_rd, fwd_data = mem_result.
REQ-020 SHALL add zero latency: a result is visible at the outputs in the cycle after its EX-stage inputs are captured.

Reset
REQ-021 SHALL clear the EX/MEM register on rst, so every output reads 0 (io_out = 0), immediately and asynchronously.
REQ-022 SHALL leave data-memory contents unreset; reads of never-written locations are X in simulation.
REQ-023 SHALL drop a store pending in the MEM stage if rst asserts before the committing edge.

Configuration
REQ-024 SHALL, with MEM_IO_EN defined, map address 8'hFF to I/O: a store updates the io_out register and not memory; a load returns io_in.
REQ-025 SHALL, with MEM_IO_EN defined, make the io_out update obey the same stall/flush gating as REQ-014.
REQ-026 SHALL, without MEM_IO_EN, treat 8'hFF as ordinary memory when DEPTH=256, and tie io_out to 0.

Structure
REQ-027 SHALL take DATA_W=8, REG_ADDR_W=2 and IO_ADDR=8'hFF from the shared processor package.
REQ-028 SHALL isolate the storage in a sub-module data_mem (synchronous write, asynchronous read); the pipeline register and muxing stay in mem_stage.

Verification
REQ-029 SHALL cover: store 8'h5A to 8'h10, then load 8'h10 into rd=2 -> mem_result=8'h5A, mem_rd=2, mem_reg_write=1.
REQ-030 SHALL cover: ALU op with result 8'h33, rd=1 -> mem_result=8'h33, fwd_valid=1, fwd_rd=1, fwd_data=8'h33, mem_is_load=0.
REQ-031 SHALL cover: store 8'hA5 to 8'h20 held by stall for 3 cycles -> exactly one memory write, outputs stable throughout, later load returns 8'hA5.
REQ-032 SHALL cover: flush=1 with stall=1 while a store of 8'h77 to 8'h30 sits in EX -> bubble captured, mem[8'h30] unchanged, all outputs 0.
REQ-033 SHALL cover: rst pulse mid-operation during a pending store -> all outputs 0 at once, store dropped.
REQ-034 SHALL cover (MEM_IO_EN): store 8'hC3 to 8'hFF -> io_out=8'hC3; with io_in=8'h3C, load 8'hFF -> mem_result=8'h3C.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared processor constants and the EX/MEM pipeline entry type used by the memory stage.
package mem_stage_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 2;
  localparam logic [DATA_W-1:0] IO_ADDR = 8'hFF;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     store_data;
  } ex_mem_t;

  localparam ex_mem_t BUBBLE = '0;

endpackage

// File: rtl/mem_stage_data_mem.sv
// Data memory for the MEM stage: synchronous write, asynchronous read, contents never reset.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, load/store to data memory, forwarding outputs.
// Define MEM_IO_EN to map address IO_ADDR to the io_in/io_out port pair.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [DATA_W-1:0]     mem_result,
  output logic                  mem_is_load,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
  input  logic [DATA_W-1:0]     io_in,
  output logic [DATA_W-1:0]     io_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ex_mem_t           ex_in;
  ex_mem_t           ex_mem;
  logic [AW-1:0]     addr;
  logic              commit;
  logic              is_io;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign ex_in = '{reg_write:  ex_reg_write,
                   mem_read:   ex_mem_read,
                   mem_write:  ex_mem_write,
                   rd:         ex_rd,
                   alu_result: ex_alu_result,
                   store_data: ex_store_data};

  // Flush wins over stall so a stalled stage can still be squashed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem <= BUBBLE;
    end else if (flush) begin
      ex_mem <= BUBBLE;
    end else if (!stall) begin
      ex_mem <= ex_in;
    end
  end

  assign addr = ex_mem.alu_result[AW-1:0];

  // A store commits only on the edge that moves it out of MEM, so stalls never repeat it.
  assign commit = ex_mem.mem_write && !stall && !flush;

`ifdef MEM_IO_EN
  logic [DATA_W-1:0] io_reg;

  assign is_io = (ex_mem.alu_result == IO_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_reg <= '0;
    end else if (commit && is_io) begin
      io_reg <= ex_mem.store_data;
    end
  end

  assign io_out = io_reg;
`else
  assign is_io  = 1'b0;
  assign io_out = '0;
`endif

  assign mem_we = commit && !is_io;

  data_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr),
    .wdata(ex_mem.store_data),
    .rdata(mem_rdata)
  );

  always_comb begin
    mem_result = ex_mem.alu_result;
    if (ex_mem.mem_read) begin
      mem_result = is_io ? io_in : mem_rdata;
    end
  end

  assign mem_reg_write = ex_mem.reg_write;
  assign mem_rd        = ex_mem.rd;
  assign mem_is_load   = ex_mem.mem_read;
  assign fwd_valid     = ex_mem.reg_write;
  assign fwd_rd        = ex_mem.rd;
  assign fwd_data      = mem_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against a
// transaction-level model (one pending MEM entry plus a byte array for memory).
module tb_mem_stage;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, flush;
  logic       ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0] ex_rd;
  logic [7:0] ex_alu_result, ex_store_data;
  logic       mem_reg_write, mem_is_load, fwd_valid;
  logic [1:0] mem_rd, fwd_rd;
  logic [7:0] mem_result, fwd_data, io_in, io_out;

  int check_count = 0;
  int error_count = 0;
  int write_count = 0;

  // Model of the instruction currently in MEM, and of the data memory / IO register.
  typedef struct {
    bit       rw;
    bit       mr;
    bit       mw;
    bit [1:0] rd;
    bit [7:0] alu;
    bit [7:0] sd;
  } txn_t;

  txn_t     cur;
  bit [7:0] mdl_mem [DEPTH];
  bit       written [DEPTH];
  bit [7:0] mdl_io;

  mem_stage #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_rd        (ex_rd),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .mem_reg_write(mem_reg_write),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .mem_is_load  (mem_is_load),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .io_in        (io_in),
    .io_out       (io_out)
  );

  always #5 clk = ~clk;

  // Count actual memory writes so a stalled store can be shown to land exactly once.
  always @(posedge clk) begin
    if (dut.u_mem.we === 1'b1) write_count++;
  end

  task automatic check_output(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit is_io_addr(input bit [7:0] a);
`ifdef MEM_IO_EN
    return a == 8'hFF;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    int       idx;
    bit       known;
    bit [7:0] exp_result;
    idx        = int'(cur.alu) % DEPTH;
    known      = 1'b1;
    exp_result = cur.alu;
    if (cur.mr) begin
      if (is_io_addr(cur.alu)) exp_result = io_in;
      else begin
        exp_result = mdl_mem[idx];
        known      = written[idx];
      end
    end
    check_output({tag, ".reg_write"}, 8'(mem_reg_write), 8'(cur.rw));
    check_output({tag, ".rd"},        8'(mem_rd),        8'(cur.rd));
    check_output({tag, ".is_load"},   8'(mem_is_load),   8'(cur.mr));
    check_output({tag, ".fwd_valid"}, 8'(fwd_valid),     8'(cur.rw));
    check_output({tag, ".fwd_rd"},    8'(fwd_rd),        8'(cur.rd));
    check_output({tag, ".io_out"},    io_out,            mdl_io);
    if (known) begin
      check_output({tag, ".result"},   mem_result, exp_result);
      check_output({tag, ".fwd_data"}, fwd_data,   exp_result);
    end
  endtask

  // Drive one EX entry plus control, clock it, advance the model, then check at negedge.
  task automatic apply_stimulus(input string tag, input bit rw, input bit mr, input bit mw,
                                input bit [1:0] rd, input bit [7:0] alu, input bit [7:0] sd,
                                input bit st, input bit fl);
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_rd         = rd;
    ex_alu_result = alu;
    ex_store_data = sd;
    stall         = st;
    flush         = fl;
    @(posedge clk);
    if (cur.mw && !st && !fl) begin
      if (is_io_addr(cur.alu)) mdl_io = cur.sd;
      else begin
        mdl_mem[int'(cur.alu) % DEPTH] = cur.sd;
        written[int'(cur.alu) % DEPTH] = 1'b1;
      end
    end
    if (fl) cur = '{default: '0};
    else if (!st) cur = '{rw: rw, mr: mr, mw: mw, rd: rd, alu: alu, sd: sd};
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic bubble(input string tag);
    apply_stimulus(tag, 0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0);
  endtask

  initial begin
    bit [7:0] addr_set [6];
    addr_set = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hFF, 8'h05};
    cur    = '{default: '0};
    mdl_io = 8'h00;
    rst = 1'b1; stall = 0; flush = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_rd = 0; ex_alu_result = 0; ex_store_data = 0;
    io_in = 8'h3C;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Store then dependent load.
    apply_stimulus("st10", 0, 0, 1, 2'd0, 8'h10, 8'h5A, 0, 0);
    apply_stimulus("ld10", 1, 1, 0, 2'd2, 8'h10, 8'h00, 0, 0);
    check_output("ld10_const", mem_result, 8'h5A);
    check_output("ld10_rd", 8'(mem_rd), 8'd2);

    // Plain ALU result forwarding.
    apply_stimulus("alu33", 1, 0, 0, 2'd1, 8'h33, 8'h00, 0, 0);
    check_output("alu33_fwd", fwd_data, 8'h33);
    check_output("alu33_fwd_rd", 8'(fwd_rd), 8'd1);
    check_output("alu33_is_load", 8'(mem_is_load), 8'd0);

    // Store held three cycles by stall: one write only.
    apply_stimulus("st20", 0, 0, 1, 2'd0, 8'h20, 8'hA5, 0, 0);
    write_count = 0;
    for (int i = 0; i < 3; i++)
      apply_stimulus("st20_stall", 1, 1, 0, 2'd3, 8'h99, 8'h00, 1, 0);
    bubble("st20_release");
    check_output("st20_writes", 8'(write_count), 8'd1);
    apply_stimulus("ld20", 1, 1, 0, 2'd3, 8'h20, 8'h00, 0, 0);
    check_output("ld20_const", mem_result, 8'hA5);

    // Flush with stall while a store sits in EX.
    apply_stimulus("st30_pre", 0, 0, 1, 2'd0, 8'h30, 8'h11, 0, 0);
    bubble("st30_commit");
    apply_stimulus("flush30", 1, 0, 1, 2'd2, 8'h30, 8'h77, 1, 1);
    check_output("flush30_result", mem_result, 8'h00);
    check_output("flush30_rw", 8'(mem_reg_write), 8'd0);
    bubble("flush30_after");
    apply_stimulus("ld30", 1, 1, 0, 2'd1, 8'h30, 8'h00, 0, 0);
    check_output("ld30_const", mem_result, 8'h11);

    // Reset while a store is pending in MEM.
    apply_stimulus("st40_pre", 0, 0, 1, 2'd0, 8'h40, 8'h22, 0, 0);
    bubble("st40_commit");
    apply_stimulus("st40_pend", 1, 0, 1, 2'd3, 8'h40, 8'h99, 0, 0);
    write_count = 0;
    rst = 1'b1;
    #1;
    cur = '{default: '0};
    mdl_io = 8'h00;
    check_all("rst_async");
    check_output("rst_result", mem_result, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check_output("rst_writes", 8'(write_count), 8'd0);
    apply_stimulus("ld40", 1, 1, 0, 2'd0, 8'h40, 8'h00, 0, 0);
    check_output("ld40_const", mem_result, 8'h22);

`ifdef MEM_IO_EN
    apply_stimulus("stFF", 0, 0, 1, 2'd0, 8'hFF, 8'hC3, 0, 0);
    bubble("stFF_commit");
    check_output("io_out_const", io_out, 8'hC3);
    io_in = 8'h3C;
    apply_stimulus("ldFF", 1, 1, 0, 2'd1, 8'hFF, 8'h00, 0, 0);
    check_output("ldFF_const", mem_result, 8'h3C);
`endif

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      bit [7:0] a;
      int       op;
      bit       rw, mr, mw;
      a  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : addr_set[$urandom_range(0, 5)];
      op = $urandom_range(0, 3);
      rw = (op != 2) ? 1'b1 : 1'b0;
      mr = (op == 1) || (op == 3);
      mw = (op >= 2);
      if (op == 3) rw = 1'($urandom_range(0, 1));
      io_in = 8'($urandom_range(0, 255));
      apply_stimulus("rand", rw, mr, mw, 2'($urandom_range(0, 3)), a, 8'($urandom_range(0, 255)),
                     $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
